// File: rtl/ob_cmd_issuer.sv
// Host-side order-book command issuer: stamps client requests with uids, tracks them
// in order, matches responses against the oldest entry and reports completions.
module ob_cmd_issuer #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned LAT_W           = 16,
    parameter logic [31:0] UID_INIT        = 32'h0000_0001
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               req_vld,
    input  logic [2:0]                         req_opcode,
    output logic                               req_rdy,
    output logic                               cmd_vld,
    output logic [31:0]                        cmd_uid,
    output logic [2:0]                         cmd_opcode,
    input  logic                               cmd_accept,
    input  logic                               rsp_vld,
    input  logic [31:0]                        rsp_uid,
    input  logic [2:0]                         rsp_status,
    output logic                               cpl_vld,
    output logic [31:0]                        cpl_uid,
    output logic [2:0]                         cpl_status,
    output logic [LAT_W-1:0]                   cpl_latency,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    input  logic                               drain_req,
    output logic                               drain_done,
    input  logic                               clr_err,
    output logic                               err_bad_opcode,
    output logic                               err_uid_mismatch,
    output logic                               err_unexpected_rsp
);

    localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic [31:0]      uid;
        logic [LAT_W-1:0] ts;
    } trk_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LAT_W-1:0] r_cyc;
    logic [31:0]      r_uid;
    trk_t             r_fifo [MAX_OUTSTANDING];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;

    trk_t w_head;
    logic w_req_rdy;
    logic w_acc;
    logic w_push;
    logic w_bad;
    logic w_pop;
    logic w_match;
    logic w_mismatch;
    logic w_unexp;

    // Acceptance and FIFO handshake decode; full is judged on the pre-pop count.
    always_comb begin
        w_head     = r_fifo[r_rptr];
        w_req_rdy  = (r_state == ST_RUN) & (~cmd_vld | cmd_accept) &
                     (r_cnt < CW'(MAX_OUTSTANDING));
        w_acc      = req_vld & w_req_rdy;
        w_push     = w_acc & (req_opcode inside {3'd1, 3'd2, 3'd3});
        w_bad      = w_acc & req_opcode[2];
        w_pop      = rsp_vld & (r_cnt != '0);
        w_match    = w_pop & (rsp_uid == w_head.uid);
        w_mismatch = w_pop & ~w_match;
        w_unexp    = rsp_vld & (r_cnt == '0);
    end

    assign req_rdy     = w_req_rdy;
    assign outstanding = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!drain_req)                         w_state_nxt = ST_RUN;
                else if ((r_cnt == '0) && !cmd_vld)     w_state_nxt = ST_DONE;
            end
            ST_DONE:  if (!drain_req) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Tracking storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= '{uid: r_uid, ts: r_cyc};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state            <= ST_RUN;
            r_cyc              <= '0;
            r_uid              <= UID_INIT;
            r_wptr             <= '0;
            r_rptr             <= '0;
            r_cnt              <= '0;
            cmd_vld            <= 1'b0;
            cmd_uid            <= '0;
            cmd_opcode         <= '0;
            cpl_vld            <= 1'b0;
            cpl_uid            <= '0;
            cpl_status         <= '0;
            cpl_latency        <= '0;
            drain_done         <= 1'b0;
            err_bad_opcode     <= 1'b0;
            err_uid_mismatch   <= 1'b0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            drain_done <= (w_state_nxt == ST_DONE);
            r_cyc      <= r_cyc + LAT_W'(1);
            r_cnt      <= r_cnt + CW'(w_push) - CW'(w_pop);

            if (w_push) begin
                cmd_vld    <= 1'b1;
                cmd_uid    <= r_uid;
                cmd_opcode <= req_opcode;
                r_uid      <= r_uid + 32'd1;
                r_wptr     <= r_wptr + AW'(1);
            end else if (cmd_accept) begin
                cmd_vld <= 1'b0;
            end

            cpl_vld <= w_match;
            if (w_pop) begin
                r_rptr      <= r_rptr + AW'(1);
                cpl_uid     <= w_head.uid;
                cpl_status  <= rsp_status;
                cpl_latency <= r_cyc - w_head.ts;
            end

            // A new error event outranks a simultaneous clear.
            err_bad_opcode     <= (err_bad_opcode     & ~clr_err) | w_bad;
            err_uid_mismatch   <= (err_uid_mismatch   & ~clr_err) | w_mismatch;
            err_unexpected_rsp <= (err_unexpected_rsp & ~clr_err) | w_unexp;
        end
    end

endmodule

// File: tb/tb_ob_cmd_issuer.sv
// Self-checking bench for ob_cmd_issuer: directed scenarios plus a randomized run,
// all compared against a queue-based transaction model.
module tb_ob_cmd_issuer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        req_vld, cmd_accept, rsp_vld, drain_req, clr_err;
    logic [2:0]  req_opcode, rsp_status;
    logic [31:0] rsp_uid;
    logic        req_rdy, cmd_vld, cpl_vld, drain_done;
    logic [31:0] cmd_uid, cpl_uid;
    logic [2:0]  cmd_opcode, cpl_status;
    logic [LW-1:0] cpl_latency;
    logic [3:0]  outstanding;
    logic        err_bad_opcode, err_uid_mismatch, err_unexpected_rsp;

    logic        b_req_vld, b_cmd_accept, b_rsp_vld;
    logic [2:0]  b_req_opcode;
    logic [31:0] b_rsp_uid;
    logic        b_req_rdy, b_cmd_vld, b_cpl_vld, b_drain_done;
    logic [31:0] b_cmd_uid, b_cpl_uid;
    logic [2:0]  b_cmd_opcode, b_cpl_status;
    logic [LW-1:0] b_cpl_latency;
    logic [3:0]  b_outstanding;
    logic        b_err_bad, b_err_mis, b_err_unexp;

    always #5 clk = ~clk;

    ob_cmd_issuer #(.MAX_OUTSTANDING(DEPTH), .LAT_W(LW), .UID_INIT(32'h0000_0001)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_vld(req_vld), .req_opcode(req_opcode), .req_rdy(req_rdy),
        .cmd_vld(cmd_vld), .cmd_uid(cmd_uid), .cmd_opcode(cmd_opcode), .cmd_accept(cmd_accept),
        .rsp_vld(rsp_vld), .rsp_uid(rsp_uid), .rsp_status(rsp_status),
        .cpl_vld(cpl_vld), .cpl_uid(cpl_uid), .cpl_status(cpl_status), .cpl_latency(cpl_latency),
        .outstanding(outstanding), .drain_req(drain_req), .drain_done(drain_done),
        .clr_err(clr_err), .err_bad_opcode(err_bad_opcode),
        .err_uid_mismatch(err_uid_mismatch), .err_unexpected_rsp(err_unexpected_rsp)
    );

    ob_cmd_issuer #(.MAX_OUTSTANDING(DEPTH), .LAT_W(LW), .UID_INIT(32'hFFFF_FFFE)) dut_wrap (
        .clk(clk), .arst_n(arst_n),
        .req_vld(b_req_vld), .req_opcode(b_req_opcode), .req_rdy(b_req_rdy),
        .cmd_vld(b_cmd_vld), .cmd_uid(b_cmd_uid), .cmd_opcode(b_cmd_opcode), .cmd_accept(b_cmd_accept),
        .rsp_vld(b_rsp_vld), .rsp_uid(b_rsp_uid), .rsp_status(3'd0),
        .cpl_vld(b_cpl_vld), .cpl_uid(b_cpl_uid), .cpl_status(b_cpl_status), .cpl_latency(b_cpl_latency),
        .outstanding(b_outstanding), .drain_req(1'b0), .drain_done(b_drain_done),
        .clr_err(1'b0), .err_bad_opcode(b_err_bad),
        .err_uid_mismatch(b_err_mis), .err_unexpected_rsp(b_err_unexp)
    );

    typedef struct {
        logic [31:0]   uid;
        logic [LW-1:0] ts;
    } ent_t;

    // Transaction-level model: outstanding queue plus the visible output values.
    ent_t          q[$];
    int            m_st;
    logic [31:0]   m_uid;
    logic [LW-1:0] m_cyc;
    logic          m_cmd_vld, m_cpl_vld, m_done, m_eb, m_em, m_eu;
    logic [31:0]   m_cmd_uid, m_cpl_uid;
    logic [2:0]    m_cmd_op, m_cpl_st;
    logic [LW-1:0] m_cpl_lat;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_st = 0; m_uid = 32'h1; m_cyc = '0;
        m_cmd_vld = 0; m_cmd_uid = '0; m_cmd_op = '0;
        m_cpl_vld = 0; m_cpl_uid = '0; m_cpl_st = '0; m_cpl_lat = '0;
        m_done = 0; m_eb = 0; m_em = 0; m_eu = 0;
    endtask

    task automatic check_outs();
        chk("cmd_vld", cmd_vld, m_cmd_vld);
        chk("cmd_uid", cmd_uid, m_cmd_uid);
        chk("cmd_opcode", cmd_opcode, m_cmd_op);
        chk("cpl_vld", cpl_vld, m_cpl_vld);
        if (m_cpl_vld) begin
            chk("cpl_uid", cpl_uid, m_cpl_uid);
            chk("cpl_status", cpl_status, m_cpl_st);
            chk("cpl_latency", cpl_latency, m_cpl_lat);
        end
        chk("outstanding", outstanding, q.size());
        chk("drain_done", drain_done, m_done);
        chk("err_bad_opcode", err_bad_opcode, m_eb);
        chk("err_uid_mismatch", err_uid_mismatch, m_em);
        chk("err_unexpected_rsp", err_unexpected_rsp, m_eu);
    endtask

    // One clock: check req_rdy, advance the model from the applied inputs, check outputs.
    task automatic cycle();
        bit   rdy, acc, sb, sm, su, cv_pre;
        int   sz_pre;
        ent_t h;
        #1;
        rdy = (m_st == 0) && (!m_cmd_vld || cmd_accept) && (q.size() < DEPTH);
        chk("req_rdy", req_rdy, rdy);
        sz_pre = q.size(); cv_pre = m_cmd_vld;
        acc = req_vld && rdy;
        sb = 0; sm = 0; su = 0;
        m_cpl_vld = 0;
        if (rsp_vld) begin
            if (q.size() > 0) begin
                h = q.pop_front();
                if (h.uid == rsp_uid) begin
                    m_cpl_vld = 1; m_cpl_uid = h.uid; m_cpl_st = rsp_status;
                    m_cpl_lat = m_cyc - h.ts;
                end else sm = 1;
            end else su = 1;
        end
        if (acc && (req_opcode inside {3'd1, 3'd2, 3'd3})) begin
            m_cmd_vld = 1; m_cmd_uid = m_uid; m_cmd_op = req_opcode;
            q.push_back('{m_uid, m_cyc});
            m_uid = m_uid + 32'd1;
        end else if (cmd_accept) m_cmd_vld = 0;
        if (acc && req_opcode >= 3'd4) sb = 1;
        m_eb = (m_eb && !clr_err) || sb;
        m_em = (m_em && !clr_err) || sm;
        m_eu = (m_eu && !clr_err) || su;
        case (m_st)
            0: if (drain_req) m_st = 1;
            1: if (!drain_req) m_st = 0; else if (sz_pre == 0 && !cv_pre) m_st = 2;
            default: if (!drain_req) m_st = 0;
        endcase
        m_done = (m_st == 2);
        m_cyc = m_cyc + LW'(1);
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic flush();
        for (int k = 0; k < 2 * DEPTH && q.size() > 0; k++) begin
            rsp_vld = 1; rsp_uid = q[0].uid; rsp_status = 3'd0;
            cycle();
        end
        rsp_vld = 0;
    endtask

    task automatic do_reset();
        #2;
        arst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]   exp_uid;
        logic [LW-1:0] ts;
        int            r;

        req_vld = 0; req_opcode = 0; cmd_accept = 0; rsp_vld = 0; rsp_uid = 0;
        rsp_status = 0; drain_req = 0; clr_err = 0;
        b_req_vld = 0; b_req_opcode = 0; b_cmd_accept = 0; b_rsp_vld = 0; b_rsp_uid = 0;
        arst_n = 1'b0;
        model_reset();
        #12;
        check_outs();
        chk("wrap_reset_outstanding", b_outstanding, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // uid wrap on the second instance
        b_req_vld = 1; b_req_opcode = 3'd1; b_cmd_accept = 1;
        cycle(); chk("wrap_uid0", b_cmd_uid, 32'hFFFF_FFFE);
        cycle(); chk("wrap_uid1", b_cmd_uid, 32'hFFFF_FFFF);
        cycle(); chk("wrap_uid2", b_cmd_uid, 32'h0000_0000);
        b_req_vld = 0;
        cycle(); chk("wrap_outstanding", b_outstanding, 3);
        b_rsp_vld = 1;
        b_rsp_uid = 32'hFFFF_FFFE; cycle(); chk("wrap_cpl0", {b_cpl_vld, b_cpl_uid}, {1'b1, 32'hFFFF_FFFE});
        b_rsp_uid = 32'hFFFF_FFFF; cycle(); chk("wrap_cpl1", {b_cpl_vld, b_cpl_uid}, {1'b1, 32'hFFFF_FFFF});
        b_rsp_uid = 32'h0000_0000; cycle(); chk("wrap_cpl2", {b_cpl_vld, b_cpl_uid}, {1'b1, 32'h0});
        b_rsp_vld = 0;
        cycle();
        chk("wrap_empty", b_outstanding, 0);
        chk("wrap_no_mismatch", b_err_mis, 0);

        // three back-to-back Buys and their responses
        req_vld = 1; req_opcode = 3'd2; cmd_accept = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("buy_uid", cmd_uid, 32'(i + 1));
        end
        req_vld = 0;
        cycle();
        chk("buy_outstanding", outstanding, 3);
        for (int i = 0; i < 3; i++) begin
            rsp_vld = 1; rsp_uid = 32'(i + 1); rsp_status = (i == 2) ? 3'd1 : 3'd0;
            cycle();
            chk("buy_cpl", {cpl_vld, cpl_uid, cpl_status}, {1'b1, 32'(i + 1), (i == 2) ? 3'd1 : 3'd0});
        end
        rsp_vld = 0;
        cycle();
        chk("buy_drained", outstanding, 0);

        // fill to depth; a response in the blocked cycle frees room for the next one
        req_vld = 1; req_opcode = 3'd2; cmd_accept = 1;
        repeat (DEPTH) cycle();
        cycle();
        chk("full_rdy", req_rdy, 0);
        chk("full_count", outstanding, DEPTH);
        rsp_vld = 1; rsp_uid = q[0].uid; rsp_status = 0;
        cycle();
        rsp_vld = 0;
        cycle();
        chk("full_refill", outstanding, DEPTH);
        req_vld = 0;
        cycle();
        flush();
        cycle();

        // backpressure holds the command; latency of 10 cycles
        req_vld = 1; req_opcode = 3'd3; cmd_accept = 0;
        exp_uid = m_uid; ts = m_cyc;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_cmd", {cmd_vld, cmd_uid, cmd_opcode}, {1'b1, exp_uid, 3'd3});
            chk("hold_rdy", req_rdy, 0);
        end
        req_vld = 0; cmd_accept = 1;
        cycle();
        for (int k = 0; k < 20 && m_cyc != LW'(ts + LW'(10)); k++) cycle();
        rsp_vld = 1; rsp_uid = exp_uid; rsp_status = 0;
        cycle();
        chk("lat10", {cpl_vld, cpl_latency}, {1'b1, LW'(10)});
        rsp_vld = 0;

        // Nop, bad opcode, mismatch, unexpected, clear
        do_reset();
        req_vld = 1; cmd_accept = 1;
        req_opcode = 3'd0; cycle();
        req_opcode = 3'd5; cycle();
        chk("bad_no_cmd", cmd_vld, 0);
        chk("bad_err", err_bad_opcode, 1);
        req_opcode = 3'd3; cycle();
        chk("sell_uid1", cmd_uid, 32'd1);
        req_vld = 0; cycle();
        rsp_vld = 1; rsp_uid = 32'd7; cycle();
        chk("mis_err", {err_uid_mismatch, cpl_vld, outstanding}, {1'b1, 1'b0, 4'd0});
        cycle();
        chk("unexp_err", err_unexpected_rsp, 1);
        clr_err = 1; cycle();
        chk("set_wins", err_unexpected_rsp, 1);
        rsp_vld = 0; cycle();
        clr_err = 0;
        chk("clr_all", {err_bad_opcode, err_uid_mismatch, err_unexpected_rsp}, 3'b000);

        // drain handshake
        req_vld = 1; req_opcode = 3'd2; cmd_accept = 1;
        cycle(); cycle();
        req_vld = 0; drain_req = 1;
        cycle();
        req_vld = 1;
        cycle();
        chk("drain_rdy", req_rdy, 0);
        req_vld = 0;
        flush();
        chk("drain_not_yet", drain_done, 0);
        cycle();
        chk("drain_done", drain_done, 1);
        drain_req = 0;
        cycle();
        chk("drain_drop", drain_done, 0);
        req_vld = 1; req_opcode = 3'd1;
        cycle();
        chk("run_again", cmd_vld, 1);
        do_reset();
        chk("reset_mid", {cmd_vld, outstanding}, {1'b0, 4'd0});
        req_vld = 0;
        cycle();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            r = int'($urandom_range(0, 15));
            req_vld    = ($urandom_range(0, 2) != 0);
            req_opcode = (r < 11) ? 3'(1 + r % 3) : ((r == 11) ? 3'd0 : 3'(r - 8));
            cmd_accept = ($urandom_range(0, 3) != 0);
            rsp_status = 3'($urandom_range(0, 1));
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                rsp_vld = 1;
                rsp_uid = ($urandom_range(0, 15) == 0) ? $urandom : q[0].uid;
            end else begin
                rsp_vld = ($urandom_range(0, 39) == 0);
                rsp_uid = $urandom;
            end
            clr_err = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
            cycle();
        end
        req_vld = 0; drain_req = 0; clr_err = 0; cmd_accept = 1;
        flush();
        cycle();
        chk("final_empty", outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
